uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Round-robin scheduler that shares one UART byte transmitter between `NUM_REQ` requesters, each submitting a fixed-length multi-byte frame. It captures the granted frame, sequences its bytes into the transmitter with single-cycle start pulses, waits on the transmitter's byte-done pulse, and optionally enforces an idle guard gap between frames. It sits between the application-side frame sources and the serial byte transmitter whose line output drives `Txd`.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `BYTES_PER_FRAME`, 2: bytes per frame, 1..16.
- `GUARD_CYCLES`, 50: idle cycles between frames, ≥1; used only with the guard feature.

Clock and reset: one clock; reset is asynchronous and active-low.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  NUM_REQ  level request per requester.
- `frame_data`  in  NUM_REQ*BYTES_PER_FRAME*8  frame of requester i at `[i*BYTES_PER_FRAME*8 +: BYTES_PER_FRAME*8]`; byte 0 in the low 8 bits.
- `grant`  out  NUM_REQ  one-hot owner of the transmitter, 0 when idle.
- `done`  out  NUM_REQ  one-cycle pulse to the owner after its last byte.
- `busy`  out  1  high whenever state ≠ IDLE.
- `tx_data`  out  8  byte to transmitter.
- `tx_start`  out  1  one-cycle start pulse to transmitter.
- `tx_done`  in  1  one-cycle byte-complete pulse from transmitter.

## Operation
- States: IDLE, SEND, GUARD.
- IDLE: when `req` ≠ 0, pick the winner i by round-robin from pointer `ptr`. On that edge: capture the whole frame of i into an internal buffer, set `grant` = 1<<i, set `tx_data` = byte 0, pulse `tx_start`, set byte index to 0, set `ptr` = (i+1) mod NUM_REQ, go to SEND.
- SEND: ignore everything until `tx_done`. On `tx_done` with index < BYTES_PER_FRAME-1: increment index, load the next byte into `tx_data`, pulse `tx_start`. On `tx_done` with the last index: pulse `done[i]`, clear `grant`, go to GUARD (macro defined) or IDLE (macro undefined).
- GUARD: count 0..GUARD_CYCLES-1, then go to IDLE. Requests are not arbitrated in GUARD.
- Data is captured at grant. The requester may change `frame_data` or drop `req` after `grant` rises. A frame always completes once granted; there is no abort.
- A requester that keeps `req` high after `done` re-competes normally. The rotated pointer gives every other pending requester priority first.
- `tx_done` in IDLE or GUARD is ignored. `tx_done` arriving in the same cycle as `tx_start` is ignored.
- `tx_data` stays stable from `tx_start` until the following accepted `tx_done`.

## Timing
- Reset values: `grant`=0, `done`=0, `busy`=0, `tx_start`=0, `tx_data`=8'h00, `ptr`=0 (req0 highest), index=0, guard counter=0, state IDLE.
- Reset asserted mid-frame forces reset values immediately. The downstream transmitter is not reset by this block.
- `req` seen at edge N: `grant`, `busy`, `tx_start` and byte 0 are visible after edge N (a 1-cycle latency).
- `tx_done` at edge M, not the last byte: the next `tx_start` is visible after edge M.
- `tx_done` at edge M, last byte: `done` is high for exactly one cycle after edge M, and `grant` clears in the same cycle.
- With guard: the earliest next grant is GUARD_CYCLES+1 edges after `done`. Without guard: the earliest next grant is 1 edge after `done`.
- Index width is `$clog2(BYTES_PER_FRAME)`, minimum 1 bit. The guard counter width is `$clog2(GUARD_CYCLES+1)`. `ptr` wraps modulo NUM_REQ.

## Configuration
- `UART_SCHED_GUARD_EN` defined: the GUARD state and counter exist, and the inter-frame gap is GUARD_CYCLES.
- `UART_SCHED_GUARD_EN` undefined: GUARD state and counter are removed, SEND returns directly to IDLE, and `GUARD_CYCLES` is ignored.

## Structure
- Package `uart_sched_pkg`:
  - state enum (IDLE, SEND, GUARD);
  - default constants for NUM_REQ, BYTES_PER_FRAME and GUARD_CYCLES;
  - byte width constant 8.
- Sub-module `rr_picker`: combinational one-hot round-robin select from `req` and `ptr`, returning the winner index and a valid flag.

## Test plan
- Single request: req=4'b0010, frame1=16'hA55A. Expect `grant`=4'b0010 one cycle later, `tx_data`=8'h5A with `tx_start`. After `tx_done`, `tx_data`=8'hA5 with `tx_start`. After the second `tx_done`, `done[1]` pulses and `grant`=0.
- Contention: req=4'b1111 held constant. Expect grants in order 0,1,2,3,0, each full frame sent, `done` pulses matching the grant order.
- Data capture: change frame0 and drop req0 the cycle after grant. Expect the original captured bytes transmitted and `done[0]` still pulsed.
- Guard (macro defined, GUARD_CYCLES=50): req0 held. Expect the next `grant` 51 edges after `done[0]`. With the macro undefined, expect 1 edge.
- Spurious `tx_done` in IDLE, and `tx_done` in the same cycle as `tx_start`: expect no state change and no extra `tx_start`.
- Reset mid-frame: `rst_n`=0 during byte 1 of 2. Expect all outputs at reset values immediately; after release with req2 pending, expect `grant`=4'b0100 (ptr back at 0).

Source files
------------

// File: rtl/uart_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_sched_pkg : shared types and defaults for the UART TX frame scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
package uart_sched_pkg;

    localparam int c_NUM_REQ_DEFAULT         = 4;
    localparam int c_BYTES_PER_FRAME_DEFAULT = 2;
    localparam int c_GUARD_CYCLES_DEFAULT    = 50;
    localparam int c_BYTE_W                  = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SEND  = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    // v is at most 2*n-2 at every call site, so one subtraction is enough.
    function automatic int rr_wrap(input int v, input int n);
        return (v >= n) ? (v - n) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_rr_picker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_picker : combinational round-robin select starting at i_ptr
// Rev 1.0
// ---------------------------------------------------------------------------
module rr_picker
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = c_NUM_REQ_DEFAULT
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [$clog2(NUM_REQ)-1:0] o_idx,
    output logic                       o_valid,
    output logic [NUM_REQ-1:0]         o_onehot
);

    localparam int c_PTR_W = $clog2(NUM_REQ);

    logic [c_PTR_W-1:0] w_cand [NUM_REQ];

    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_cand
            assign w_cand[k] = c_PTR_W'(rr_wrap(int'(i_ptr) + k, NUM_REQ));
        end
    endgenerate

    // Scan from the farthest offset down so the nearest pending requester wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) begin
                o_idx   = w_cand[k];
                o_valid = 1'b1;
            end
        end
    end

    assign o_onehot = o_valid ? (NUM_REQ'(1) << o_idx) : '0;

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_scheduler : round-robin sharing of one UART byte transmitter
// Optional inter-frame guard gap enabled by macro UART_SCHED_GUARD_EN. Rev 1.0
// ---------------------------------------------------------------------------
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ         = c_NUM_REQ_DEFAULT,
    parameter int BYTES_PER_FRAME = c_BYTES_PER_FRAME_DEFAULT,
    parameter int GUARD_CYCLES    = c_GUARD_CYCLES_DEFAULT
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_REQ-1:0]                       req,
    input  logic [NUM_REQ*BYTES_PER_FRAME*8-1:0]     frame_data,
    output logic [NUM_REQ-1:0]                       grant,
    output logic [NUM_REQ-1:0]                       done,
    output logic                                     busy,
    output logic [7:0]                               tx_data,
    output logic                                     tx_start,
    input  logic                                     tx_done
);

    localparam int c_PTR_W   = $clog2(NUM_REQ);
    localparam int c_IDX_W   = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;
    localparam int c_FRAME_W = BYTES_PER_FRAME * c_BYTE_W;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(BYTES_PER_FRAME - 1);

    state_t                r_state,    w_state_nxt;
    logic [c_PTR_W-1:0]    r_ptr,      w_ptr_nxt;
    logic [c_IDX_W-1:0]    r_idx,      w_idx_nxt;
    logic [c_FRAME_W-1:0]  r_buf,      w_buf_nxt;
    logic [NUM_REQ-1:0]    r_grant,    w_grant_nxt;
    logic [NUM_REQ-1:0]    r_done,     w_done_nxt;
    logic                  r_tx_start, w_tx_start_nxt;
    logic [c_BYTE_W-1:0]   r_tx_data,  w_tx_data_nxt;

`ifdef UART_SCHED_GUARD_EN
    localparam int c_GCNT_W = $clog2(GUARD_CYCLES + 1);
    localparam logic [c_GCNT_W-1:0] c_GCNT_LAST = c_GCNT_W'(GUARD_CYCLES - 1);
    logic [c_GCNT_W-1:0]   r_gcnt,     w_gcnt_nxt;
`else
    logic w_unused_guard;
    assign w_unused_guard = (GUARD_CYCLES > 0);
`endif

    logic [c_PTR_W-1:0]    w_win;
    logic                  w_win_vld;
    logic [NUM_REQ-1:0]    w_win_oh;
    logic [c_PTR_W-1:0]    w_win_inc;
    logic [c_FRAME_W-1:0]  w_frames [NUM_REQ];
    logic [c_FRAME_W-1:0]  w_win_frame;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_idx    (w_win),
        .o_valid  (w_win_vld),
        .o_onehot (w_win_oh)
    );

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_frames
            assign w_frames[g] = frame_data[g*c_FRAME_W +: c_FRAME_W];
        end
    endgenerate

    assign w_win_frame = w_frames[w_win];
    assign w_win_inc   = (w_win == c_PTR_W'(NUM_REQ - 1)) ? '0 : (w_win + c_PTR_W'(1));

    // The buffer holds the not-yet-sent bytes, shifted down so the next is always at [7:0].
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_idx_nxt      = r_idx;
        w_buf_nxt      = r_buf;
        w_grant_nxt    = r_grant;
        w_done_nxt     = '0;
        w_tx_start_nxt = 1'b0;
        w_tx_data_nxt  = r_tx_data;
`ifdef UART_SCHED_GUARD_EN
        w_gcnt_nxt     = r_gcnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_tx_data_nxt  = w_win_frame[c_BYTE_W-1:0];
                    w_buf_nxt      = w_win_frame >> c_BYTE_W;
                    w_grant_nxt    = w_win_oh;
                    w_tx_start_nxt = 1'b1;
                    w_idx_nxt      = '0;
                    w_ptr_nxt      = w_win_inc;
                    w_state_nxt    = S_SEND;
                end
            end
            S_SEND: begin
                // A done coinciding with our own start pulse belongs to the previous byte.
                if (tx_done && !r_tx_start) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_done_nxt  = r_grant;
                        w_grant_nxt = '0;
                        w_idx_nxt   = '0;
`ifdef UART_SCHED_GUARD_EN
                        w_gcnt_nxt  = '0;
                        w_state_nxt = S_GUARD;
`else
                        w_state_nxt = S_IDLE;
`endif
                    end else begin
                        w_idx_nxt      = r_idx + c_IDX_W'(1);
                        w_tx_data_nxt  = r_buf[c_BYTE_W-1:0];
                        w_buf_nxt      = r_buf >> c_BYTE_W;
                        w_tx_start_nxt = 1'b1;
                    end
                end
            end
            S_GUARD: begin
`ifdef UART_SCHED_GUARD_EN
                if (r_gcnt == c_GCNT_LAST) begin
                    w_gcnt_nxt  = '0;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gcnt_nxt  = r_gcnt + c_GCNT_W'(1);
                end
`else
                w_state_nxt = S_IDLE;
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_idx      <= '0;
            r_buf      <= '0;
            r_grant    <= '0;
            r_done     <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
`ifdef UART_SCHED_GUARD_EN
            r_gcnt     <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_idx      <= w_idx_nxt;
            r_buf      <= w_buf_nxt;
            r_grant    <= w_grant_nxt;
            r_done     <= w_done_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_tx_data  <= w_tx_data_nxt;
`ifdef UART_SCHED_GUARD_EN
            r_gcnt     <= w_gcnt_nxt;
`endif
        end
    end

    assign grant    = r_grant;
    assign done     = r_done;
    assign busy     = (r_state != S_IDLE);
    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler : directed self-checking bench for uart_tx_scheduler
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int NR  = 4;
    localparam int BPF = 2;
    localparam int GC  = 50;
`ifdef UART_SCHED_GUARD_EN
    localparam int GAP      = GC + 1;
    localparam bit GUARD_ON = 1'b1;
`else
    localparam int GAP      = 1;
    localparam bit GUARD_ON = 1'b0;
`endif

    logic                  clk;
    logic                  rst_n;
    logic [NR-1:0]         req;
    logic [NR*BPF*8-1:0]   frame_data;
    logic [NR-1:0]         grant;
    logic [NR-1:0]         done;
    logic                  busy;
    logic [7:0]            tx_data;
    logic                  tx_start;
    logic                  tx_done;

    int checks = 0;
    int errors = 0;
    int n;

    uart_tx_scheduler #(
        .NUM_REQ         (NR),
        .BYTES_PER_FRAME (BPF),
        .GUARD_CYCLES    (GC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .frame_data (frame_data),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .tx_done    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(output int cycles);
        cycles = 0;
        while (grant == '0 && cycles < 200) begin
            step();
            cycles++;
        end
    endtask

    task automatic send_frame(input int i, input logic [7:0] b0, input logic [7:0] b1);
        int c;
        wait_grant(c);
        check("frm_grant", 64'(grant), 64'(1) << i);
        check("frm_start0", 64'(tx_start), 64'd1);
        check("frm_byte0", 64'(tx_data), 64'(b0));
        step();
        pulse_done();
        check("frm_start1", 64'(tx_start), 64'd1);
        check("frm_byte1", 64'(tx_data), 64'(b1));
        step();
        pulse_done();
        check("frm_done", 64'(done), 64'(1) << i);
        check("frm_grant_clr", 64'(grant), 64'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = '0;
        tx_done    = 1'b0;
        frame_data = 64'h6655_4433_A55A_2211;
        repeat (3) step();
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_start", 64'(tx_start), 64'd0);
        check("rst_data", 64'(tx_data), 64'd0);
        rst_n = 1'b1;
        step();

        // Single request from requester 1, plus a done that overlaps the start pulse.
        req = 4'b0010;
        step();
        req = 4'b0000;
        check("s_grant", 64'(grant), 64'b0010);
        check("s_busy", 64'(busy), 64'd1);
        check("s_start0", 64'(tx_start), 64'd1);
        check("s_byte0", 64'(tx_data), 64'h5A);
        pulse_done();
        check("s_overlap_nostart", 64'(tx_start), 64'd0);
        check("s_overlap_data", 64'(tx_data), 64'h5A);
        check("s_overlap_grant", 64'(grant), 64'b0010);
        step();
        pulse_done();
        check("s_start1", 64'(tx_start), 64'd1);
        check("s_byte1", 64'(tx_data), 64'hA5);
        check("s_nodone_mid", 64'(done), 64'd0);
        step();
        check("s_start_pulse", 64'(tx_start), 64'd0);
        pulse_done();
        check("s_done", 64'(done), 64'b0010);
        check("s_grant_clr", 64'(grant), 64'd0);
        check("s_busy_after", 64'(busy), 64'(GUARD_ON));
        step();
        check("s_done_1cyc", 64'(done), 64'd0);

        // Spurious done while idle.
        repeat (60) step();
        pulse_done();
        check("sp_busy", 64'(busy), 64'd0);
        check("sp_start", 64'(tx_start), 64'd0);
        check("sp_grant", 64'(grant), 64'd0);
        step();
        check("sp_start2", 64'(tx_start), 64'd0);

        // Reset during byte 1 of requester 3's frame, requester 2 pending.
        req = 4'b1000;
        wait_grant(n);
        check("mr_grant", 64'(grant), 64'b1000);
        check("mr_byte0", 64'(tx_data), 64'h55);
        req = 4'b0100;
        step();
        pulse_done();
        check("mr_byte1", 64'(tx_data), 64'h66);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_rst_grant", 64'(grant), 64'd0);
        check("mr_rst_busy", 64'(busy), 64'd0);
        check("mr_rst_start", 64'(tx_start), 64'd0);
        check("mr_rst_data", 64'(tx_data), 64'd0);
        check("mr_rst_done", 64'(done), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("mr_req2_grant", 64'(grant), 64'b0100);
        check("mr_req2_byte0", 64'(tx_data), 64'h33);
        step();
        pulse_done();
        check("mr_req2_byte1", 64'(tx_data), 64'h44);
        step();
        pulse_done();
        check("mr_req2_done", 64'(done), 64'b0100);
        req = 4'b0000;

        // Pointer back at 0 after reset; full contention rotates 0,1,2,3,0.
        repeat (60) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req = 4'b1111;
        send_frame(0, 8'h11, 8'h22);
        send_frame(1, 8'h5A, 8'hA5);
        send_frame(2, 8'h33, 8'h44);
        send_frame(3, 8'h55, 8'h66);
        send_frame(0, 8'h11, 8'h22);
        req = 4'b0000;

        // Frame data captured at grant; source changes and withdraws afterwards.
        repeat (60) step();
        req = 4'b0001;
        wait_grant(n);
        check("dc_grant", 64'(grant), 64'b0001);
        check("dc_byte0", 64'(tx_data), 64'h11);
        frame_data[15:0] = 16'hBEEF;
        req = 4'b0000;
        step();
        pulse_done();
        check("dc_byte1", 64'(tx_data), 64'h22);
        step();
        pulse_done();
        check("dc_done", 64'(done), 64'b0001);

        // Inter-frame gap with requester 0 held.
        repeat (60) step();
        frame_data[15:0] = 16'h2211;
        req = 4'b0001;
        send_frame(0, 8'h11, 8'h22);
        wait_grant(n);
        check("gap_edges", 64'(n), 64'(GAP));
        check("gap_grant", 64'(grant), 64'b0001);
        step();
        pulse_done();
        step();
        pulse_done();
        req = 4'b0000;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
